// File: rtl/sprite_cmd_sender_pkg.sv
// Shared definitions for the sprite command bus: field layout, opcodes,
// request record and the word packer.
package sprite_cmd_pkg;

    localparam int COMP_W  = 6;
    localparam int CHILD_W = 5;
    localparam int COORD_W = 10;
    localparam int DATA_W  = 13;

    localparam int COMP_LSB  = 26;
    localparam int CHILD_LSB = 21;
    localparam int ACT_LSB   = 17;
    localparam int TYPE_LSB  = 14;
    localparam int TOG_BIT   = 13;

    localparam logic [3:0] ACT_UPDATE = 4'h1;
    localparam logic [3:0] ACT_TOGGLE = 4'hF;

    localparam logic [2:0] TYPE_NONE = 3'b000;
    localparam logic [2:0] TYPE_VIS  = 3'b001;
    localparam logic [2:0] TYPE_X    = 3'b010;
    localparam logic [2:0] TYPE_Y    = 3'b011;
    localparam logic [2:0] TYPE_ATTR = 3'b100;

    typedef struct packed {
        logic [COMP_W-1:0]  component;
        logic [CHILD_W-1:0] child;
        logic               visible;
        logic               flip;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] attr;
    } sprite_req_t;

    typedef enum logic [2:0] {
        S_IDLE, S_VIS, S_XPOS, S_YPOS, S_ATTR, S_SCAN, S_DONE
    } state_t;

    // {component, child, action, type, toggle, data} from MSB to LSB
    function automatic logic [31:0] pack_cmd(
        input logic [COMP_W-1:0]  component,
        input logic [CHILD_W-1:0] child,
        input logic [3:0]         action,
        input logic [2:0]         act_type,
        input logic               toggle,
        input logic [DATA_W-1:0]  data
    );
        return {component, child, action, act_type, toggle, data};
    endfunction

endpackage

// File: rtl/sprite_cmd_sender_if.sv
// Host request, frame-commit and command-word signals of the sprite sender.
interface sprite_cmd_sender_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_component;
    logic [4:0]  req_child;
    logic        req_visible;
    logic        req_flip;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic [9:0]  req_attr;
    logic        commit;
    logic        commit_busy;
    logic        frame_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_writedata;

    modport master (
        output req_valid, req_component, req_child, req_visible, req_flip,
               req_x, req_y, req_attr, commit, out_ready,
        input  req_ready, commit_busy, frame_done, out_valid, out_writedata
    );

    modport slave (
        input  req_valid, req_component, req_child, req_visible, req_flip,
               req_x, req_y, req_attr, commit, out_ready,
        output req_ready, commit_busy, frame_done, out_valid, out_writedata
    );
endinterface

// File: rtl/sprite_cmd_sender_fifo.sv
// Request FIFO: DEPTH entries of sprite_req_t, show-ahead read port.
import sprite_cmd_pkg::*;

module sprite_req_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  sprite_req_t wr_data,
    input  logic        rd_en,
    output sprite_req_t rd_data,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    sprite_req_t    mem [DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           do_wr, do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    // Extra pointer bit tells full from empty when the indices meet
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sprite_cmd_sender.sv
// Serialises sprite updates into four command words each and, on frame commit,
// emits one buffer-toggle word per component touched during the frame.
import sprite_cmd_pkg::*;

module sprite_cmd_sender #(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_IDS    = 64
) (
    input logic                clk,
    input logic                reset,
    sprite_cmd_sender_if.slave bus
);
    localparam int ID_W = $clog2(NUM_IDS);

    state_t             state, state_nxt;
    sprite_req_t        fifo_wdata, fifo_rdata, work;
    logic               fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic               commit_pending;
    logic [NUM_IDS-1:0] touched, front_sel;
    logic [ID_W-1:0]    scan_id;
    logic               tog_loaded;
    logic               out_valid;
    logic [31:0]        out_data;
    logic               load_ok, out_hs;
    logic               out_load;
    logic [31:0]        out_load_data;
    logic               scan_start, scan_next, tog_set, tog_done;
    logic               work_b;

    assign fifo_wdata = '{component: bus.req_component, child: bus.req_child,
                          visible: bus.req_visible, flip: bus.req_flip,
                          x: bus.req_x, y: bus.req_y, attr: bus.req_attr};
    assign bus.req_ready = !fifo_full && !commit_pending;
    assign fifo_wr       = bus.req_valid && bus.req_ready;

    sprite_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_hs  = out_valid && bus.out_ready;
    assign load_ok = !out_valid || bus.out_ready;
    assign work_b  = ~front_sel[work.component];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Each sprite state names the word loaded next into the output register
    always_comb begin
        state_nxt     = state;
        fifo_rd       = 1'b0;
        out_load      = 1'b0;
        out_load_data = '0;
        scan_start    = 1'b0;
        scan_next     = 1'b0;
        tog_set       = 1'b0;
        tog_done      = 1'b0;
        case (state)
            S_IDLE: begin
                // Entries already queued belong to the frame being committed,
                // so they drain before the scan starts
                if (!fifo_empty) begin
                    fifo_rd   = 1'b1;
                    state_nxt = S_VIS;
                end else if (commit_pending) begin
                    scan_start = 1'b1;
                    state_nxt  = S_SCAN;
                end
            end
            S_VIS: if (load_ok) begin
                out_load      = 1'b1;
                out_load_data = pack_cmd(work.component, work.child, ACT_UPDATE, TYPE_VIS,
                                         work_b, {work.visible, work.flip, 11'd0});
                state_nxt     = S_XPOS;
            end
            S_XPOS: if (load_ok) begin
                out_load      = 1'b1;
                out_load_data = pack_cmd(work.component, work.child, ACT_UPDATE, TYPE_X,
                                         work_b, {3'd0, work.x});
                state_nxt     = S_YPOS;
            end
            S_YPOS: if (load_ok) begin
                out_load      = 1'b1;
                out_load_data = pack_cmd(work.component, work.child, ACT_UPDATE, TYPE_Y,
                                         work_b, {3'd0, work.y});
                state_nxt     = S_ATTR;
            end
            S_ATTR: if (load_ok) begin
                out_load      = 1'b1;
                out_load_data = pack_cmd(work.component, work.child, ACT_UPDATE, TYPE_ATTR,
                                         work_b, {3'd0, work.attr});
                state_nxt     = S_IDLE;
            end
            S_SCAN: begin
                if (!touched[scan_id]) begin
                    scan_next = 1'b1;
                end else if (!tog_loaded) begin
                    if (load_ok) begin
                        out_load      = 1'b1;
                        out_load_data = pack_cmd(COMP_W'(scan_id), '0, ACT_TOGGLE, TYPE_NONE,
                                                 ~front_sel[scan_id], '0);
                        tog_set       = 1'b1;
                    end
                end else if (bus.out_ready) begin
                    // Toggle word is still the one held in the output register
                    tog_done  = 1'b1;
                    scan_next = 1'b1;
                end
                if (scan_next && scan_id == ID_W'(NUM_IDS-1)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work           <= '0;
            touched        <= '0;
            front_sel      <= '0;
            commit_pending <= 1'b0;
            scan_id        <= '0;
            tog_loaded     <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
        end else begin
            if (fifo_rd) begin
                work                         <= fifo_rdata;
                touched[fifo_rdata.component] <= 1'b1;
            end
            if (tog_done) begin
                touched[scan_id]   <= 1'b0;
                front_sel[scan_id] <= ~front_sel[scan_id];
            end
            if (state == S_DONE)  commit_pending <= 1'b0;
            else if (bus.commit)  commit_pending <= 1'b1;
            if (scan_start)      scan_id <= '0;
            else if (scan_next)  scan_id <= scan_id + ID_W'(1);
            if (tog_set)       tog_loaded <= 1'b1;
            else if (tog_done) tog_loaded <= 1'b0;
            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= out_load_data;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = out_valid;
    assign bus.out_writedata = out_data;
    assign bus.frame_done    = (state == S_DONE);
    assign bus.commit_busy   = commit_pending || state == S_SCAN || state == S_DONE;

endmodule

// File: tb/tb_sprite_cmd_sender.sv
// Scoreboard bench for sprite_cmd_sender: a reference model queues expected
// words as requests/commits are issued; a monitor pops them on each handshake.
module tb_sprite_cmd_sender;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_cmd_sender_if bus();

    sprite_cmd_sender #(.FIFO_DEPTH(DEPTH), .NUM_IDS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb [$];
    logic [63:0] m_front = '0;
    logic [63:0] m_touched = '0;
    logic [31:0] mon_exp;

    function automatic logic [31:0] mk(input logic [5:0] c, input logic [4:0] ch,
                                       input logic [3:0] a, input logic [2:0] t,
                                       input logic b, input logic [12:0] d);
        mk = (32'(c) << 26) | (32'(ch) << 21) | (32'(a) << 17) | (32'(t) << 14)
           | (32'(b) << 13) | 32'(d);
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL out_word unexpected: got=%h want=none", bus.out_writedata);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.out_writedata !== mon_exp) begin
                    bad++;
                    $display("FAIL out_word: got=%h want=%h", bus.out_writedata, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input logic [5:0] c, input logic [4:0] ch, input logic v,
                           input logic f, input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] a);
        bus.req_component = c; bus.req_child = ch; bus.req_visible = v;
        bus.req_flip = f; bus.req_x = x; bus.req_y = y; bus.req_attr = a;
    endtask

    task automatic push_sprite();
        logic       b;
        logic [5:0] c;
        c = bus.req_component;
        b = ~m_front[c];
        sb.push_back(mk(c, bus.req_child, 4'h1, 3'd1, b, {bus.req_visible, bus.req_flip, 11'd0}));
        sb.push_back(mk(c, bus.req_child, 4'h1, 3'd2, b, {3'd0, bus.req_x}));
        sb.push_back(mk(c, bus.req_child, 4'h1, 3'd3, b, {3'd0, bus.req_y}));
        sb.push_back(mk(c, bus.req_child, 4'h1, 3'd4, b, {3'd0, bus.req_attr}));
        m_touched[c] = 1'b1;
    endtask

    // Called just after a posedge; returns just after the accepting posedge
    task automatic send_req(input logic [5:0] c, input logic [4:0] ch, input logic v,
                            input logic f, input logic [9:0] x, input logic [9:0] y,
                            input logic [9:0] a);
        int n;
        n = 0;
        set_req(c, ch, v, f, x, y, a);
        bus.req_valid = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && n < 300) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            total++; bad++;
            $display("FAIL req_accept timeout: ready=%0b want=1", bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        push_sprite();
        @(posedge clk); #1 bus.req_valid = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (m_touched[i]) begin
                sb.push_back(mk(6'(i), 5'd0, 4'hF, 3'd0, ~m_front[i], 13'd0));
                m_front[i] = ~m_front[i];
            end
        end
        m_touched = '0;
        @(posedge clk); #1 bus.commit = 1'b0;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.frame_done && n < 300);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 500) begin @(negedge clk); n++; end
        total++;
        if (sb.size() != 0 || bus.out_valid) begin
            bad++;
            $display("FAIL drain: pending=%0d out_valid=%0b want 0/0", sb.size(), bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got=%b want=0", bus.out_valid); end
        total++; if (bus.out_writedata !== 32'h0) begin bad++; $display("FAIL rst_writedata: got=%h want=0", bus.out_writedata); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got=%b want=0", bus.frame_done); end
        total++; if (bus.commit_busy !== 1'b0) begin bad++; $display("FAIL rst_commit_busy: got=%b want=0", bus.commit_busy); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got=%b want=1", bus.req_ready); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] exp_w [4];
        exp_w = '{32'h28027000, 32'h2802A064, 32'h2802E0C8, 32'h28032000};
        bus.out_ready = 1'b1;
        send_req(6'h0A, 5'd0, 1'b1, 1'b0, 10'd100, 10'd200, 10'd0);
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL latency_c1: got=%b want=0", bus.out_valid); end
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL latency_c2: got=%b want=0", bus.out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_writedata !== exp_w[i]) begin
                bad++;
                $display("FAIL single_word%0d: got=%b/%h want=1/%h", i, bus.out_valid, bus.out_writedata, exp_w[i]);
            end
        end
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_end: got=%b want=0", bus.out_valid); end
        wait_drain();
    endtask

    task automatic test_commit();
        int n;
        do_commit();
        n = 0;
        while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
        total++; if (bus.out_writedata !== 32'h281E2000) begin bad++; $display("FAIL toggle_word: got=%h want=281e2000", bus.out_writedata); end
        wait_frame(n);
        total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL commit_done: got=%b want=1", bus.frame_done); end
        @(negedge clk);
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL done_pulse: got=%b want=0", bus.frame_done); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL toggle_count: left=%0d want=0", sb.size()); end
        @(posedge clk); #1;
        send_req(6'h0A, 5'd0, 1'b1, 1'b0, 10'd5, 10'd6, 10'd7);
        repeat (3) @(negedge clk);
        total++; if (bus.out_writedata !== 32'h28025000) begin bad++; $display("FAIL vis_after_flip: got=%h want=28025000", bus.out_writedata); end
        wait_drain();
    endtask

    task automatic test_stall();
        logic [31:0] held;
        int n;
        bus.out_ready = 1'b0;
        send_req(6'h11, 5'd3, 1'b0, 1'b1, 10'd321, 10'd654, 10'h2AA);
        n = 0;
        while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        held = bus.out_writedata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_writedata !== held) begin
                bad++;
                $display("FAIL stall_hold%0d: got=%b/%h want=1/%h", i, bus.out_valid, bus.out_writedata, held);
            end
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int  acc, viol, n;
        bit  stalled;
        acc = 0; stalled = 0; viol = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_req(6'(i + 1), 5'(i), i[0], i[1], 10'(i * 3), 10'(i * 5), 10'(i));
            bus.req_valid = 1'b1;
            @(negedge clk);
            if (!bus.req_ready) begin stalled = 1; break; end
            push_sprite(); acc++;
            @(posedge clk); #1;
        end
        total++; if (acc != DEPTH + 1) begin bad++; $display("FAIL full_accepts: got=%0d want=%0d", acc, DEPTH + 1); end
        if (stalled) begin
            for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.req_ready) viol++; end
            total++; if (viol != 0) begin bad++; $display("FAIL full_ready: got=%0d high cycles want=0", viol); end
            @(posedge clk); #1 bus.out_ready = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
            total++;
            if (!bus.req_ready) begin bad++; $display("FAIL full_release: ready=%b want=1", bus.req_ready); end
            else push_sprite();
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_order();
        logic [31:0] got [2];
        int k, n, viol;
        do_commit();
        wait_frame(n);
        wait_drain();
        send_req(6'h05, 5'd1, 1'b1, 1'b1, 10'd11, 10'd22, 10'd33);
        send_req(6'h02, 5'd2, 1'b1, 1'b0, 10'd44, 10'd55, 10'd66);
        wait_drain();
        do_commit();
        set_req(6'h2A, 5'd4, 1'b1, 1'b0, 10'd7, 10'd8, 10'd9);
        bus.req_valid = 1'b1;
        k = 0; n = 0; viol = 0;
        do begin
            @(negedge clk); n++;
            if (bus.req_ready) viol++;
            if (bus.out_valid && bus.out_ready) begin
                if (k < 2) got[k] = bus.out_writedata;
                k++;
            end
        end while (!bus.frame_done && n < 300);
        total++; if (k != 2) begin bad++; $display("FAIL order_count: got=%0d want=2", k); end
        total++; if (got[0] !== 32'h081E0000) begin bad++; $display("FAIL order_first: got=%h want=081e0000", got[0]); end
        total++; if (got[1] !== 32'h141E0000) begin bad++; $display("FAIL order_second: got=%h want=141e0000", got[1]); end
        total++; if (viol != 0) begin bad++; $display("FAIL busy_stall: ready high %0d cycles want=0", viol); end
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        total++;
        if (!bus.req_ready) begin bad++; $display("FAIL busy_release: ready=%b want=1", bus.req_ready); end
        else push_sprite();
        @(posedge clk); #1 bus.req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int n;
        bus.out_ready = 1'b0;
        send_req(6'h0B, 5'd6, 1'b1, 1'b0, 10'd12, 10'd34, 10'd56);
        n = 0;
        while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete(); m_front = '0; m_touched = '0;
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got=%b want=0", bus.out_valid); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        total++; if (bus.commit_busy !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle: busy=%b ready=%b want=0/1", bus.commit_busy, bus.req_ready); end
        @(posedge clk); #1;
        do_commit();
        wait_frame(n);
        total++; if (bus.frame_done !== 1'b1 || n > 66) begin bad++; $display("FAIL empty_commit: done=%b cycles=%0d want=1/<=66", bus.frame_done, n); end
        @(posedge clk); #1;
        send_req(6'h0A, 5'd0, 1'b1, 1'b0, 10'd100, 10'd200, 10'd0);
        repeat (3) @(negedge clk);
        total++; if (bus.out_writedata !== 32'h28027000) begin bad++; $display("FAIL front_cleared: got=%h want=28027000", bus.out_writedata); end
        wait_drain();
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.commit = 1'b0; bus.out_ready = 1'b0;
        set_req(6'd0, 5'd0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        test_reset();
        test_single();
        test_commit();
        test_stall();
        test_back_to_back();
        test_order();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
